// File: rtl/accel_pkg.sv
// Shared definitions for the parameter-buffer feed path.
// Lane geometry, word type, loader FSM states and row-count clamp.
package accel_pkg;

    localparam int PE_LANES      = 64;
    localparam int WORD_W        = 32;
    localparam int ROWS_PER_TILE = 32;

    typedef logic [WORD_W-1:0] param_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } param_ld_state_t;

    // Requested row counts beyond one tile saturate at a full tile.
    function automatic logic [5:0] clamp_rows(input logic [5:0] n);
        return (n > 6'(ROWS_PER_TILE)) ? 6'(ROWS_PER_TILE) : n;
    endfunction

endpackage

// File: rtl/param_row_packer.sv
// Lane register array and beat counter for param_loader.
// Packs IN_WORDS-wide beats into a 64-word row and snapshots it on completion.
module param_row_packer
    import accel_pkg::*;
#(
    parameter int IN_WORDS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              beat_en,
    input  logic [IN_WORDS*WORD_W-1:0]        beat,
    output logic [PE_LANES-1:0][WORD_W-1:0]   row,
    output logic                              row_done
);

    localparam int BEATS = PE_LANES / IN_WORDS;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    logic [CW-1:0]                    beat_cnt;
    logic [PE_LANES-1:0][WORD_W-1:0]  lanes;
    logic [PE_LANES-1:0][WORD_W-1:0]  lanes_nxt;
    logic [5:0]                       lane_idx;

    assign row_done = beat_en && (beat_cnt == LAST);

    // Merge the incoming beat into its lane slots.
    always_comb begin
        lanes_nxt = lanes;
        lane_idx  = '0;
        for (int k = 0; k < IN_WORDS; k++) begin
            lane_idx = 6'(int'(beat_cnt) * IN_WORDS + k);
            lanes_nxt[lane_idx] = beat[k*WORD_W +: WORD_W];
        end
    end

    // Beat position within the current row; restarts on a new load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (beat_en) begin
            beat_cnt <= row_done ? '0 : beat_cnt + 1'b1;
        end
    end

    // Working lanes take every beat; untouched lanes keep old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes <= '0;
        end else if (beat_en) begin
            lanes <= lanes_nxt;
        end
    end

    // Output row only changes when a row completes, so it is stable elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
        end else if (row_done) begin
            row <= lanes_nxt;
        end
    end

endmodule

// File: rtl/param_loader.sv
// Streams parameter words into 64-lane rows and writes them to the buffer.
// Optional PARAM_LOADER_CHECKSUM_EN adds a wrapping word-sum output.
module param_loader
    import accel_pkg::*;
#(
    parameter int IN_WORDS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [5:0]                        num_rows,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [32*IN_WORDS-1:0]            s_data,
    output logic [PE_LANES-1:0][WORD_W-1:0]   par_out,
    output logic                              par_write_en,
    output logic [1:0]                        sub_tile_idx,
    output logic [2:0]                        unit_tile_idx,
    output logic                              busy,
    output logic                              done
`ifdef PARAM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]                       checksum
`endif
);

    param_ld_state_t state;
    param_ld_state_t state_nxt;

    logic [5:0] rows_lat;
    logic [5:0] row_cnt;
    logic       start_acc;
    logic       hs;
    logic       row_done;

    assign start_acc = start && (state == ST_IDLE);
    assign hs        = s_valid && s_ready;

    assign sub_tile_idx  = row_cnt[4:3];
    assign unit_tile_idx = row_cnt[2:0];

    param_row_packer #(
        .IN_WORDS (IN_WORDS)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_acc),
        .beat_en  (hs),
        .beat     (s_data),
        .row      (par_out),
        .row_done (row_done)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (clamp_rows(num_rows) == 6'd0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (row_done) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_nxt = (row_cnt + 6'd1 == rows_lat) ? ST_DONE : ST_FILL;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        s_ready      = 1'b0;
        par_write_en = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state)
            ST_IDLE:  ;
            ST_FILL: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            ST_WRITE: begin
                par_write_en = 1'b1;
                busy         = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Latched row count and the row being filled/written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_lat <= '0;
            row_cnt  <= '0;
        end else if (start_acc) begin
            rows_lat <= clamp_rows(num_rows);
            row_cnt  <= '0;
        end else if (state == ST_WRITE) begin
            row_cnt <= row_cnt + 6'd1;
        end
    end

`ifdef PARAM_LOADER_CHECKSUM_EN
    logic [31:0] beat_sum;

    // Sum of the words in the current beat.
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < IN_WORDS; k++) begin
            beat_sum = beat_sum + s_data[k*32 +: 32];
        end
    end

    // Running sum of accepted words; holds once the load stops taking beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (start_acc) begin
            checksum <= '0;
        end else if (hs) begin
            checksum <= checksum + beat_sum;
        end
    end
`endif

endmodule

// File: doc/param_loader.md
# param_loader

Upstream feeder for the 64-lane parameter buffer. Accepts a stream of 32-bit parameter words, packs them into 64-word rows, and issues one buffer write per row. Each write carries the correct `sub_tile_idx`/`unit_tile_idx`, so a full tile (4 sub tiles × 8 unit tiles = 32 rows) is loaded without controller intervention. Sits between the DMA/external-memory read port and the parameter buffer's write side.

## Interface
- `IN_WORDS`, 4, 32-bit words per input beat; legal 1, 2, 4, 8, 16 (must divide 64)
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a load of `num_rows` rows; ignored while `busy`
- `num_rows`  in  6  rows to load; sampled on accepted `start`; 0 = empty load; values >32 clamp to 32
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  input beat ready
- `s_data`  in  32*IN_WORDS  beat payload; word k = `s_data[32k+31:32k]`
- `par_out`  out  [31:0] × [63:0]  assembled row, to buffer `in`
- `par_write_en`  out  1  buffer write strobe, one cycle per row
- `sub_tile_idx`  out  2  row index bits [4:3]
- `unit_tile_idx`  out  3  row index bits [2:0]
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse at end of load
- `checksum`  out  32  present only with the macro (see Configuration)

## Operation
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE: `s_ready`=0. On `start`, latch `clamp(num_rows)` and clear `row_cnt`, `beat_cnt` and checksum.
  - Nonzero count → FILL.
  - Zero count → DONE.
- FILL: `s_ready`=1. Each handshake (`s_valid & s_ready`) writes word k of the beat into lane `beat_cnt*IN_WORDS+k` and increments `beat_cnt`. The beat with `beat_cnt = 64/IN_WORDS-1` completes the row; `beat_cnt` wraps to 0 and the FSM goes to WRITE.
- WRITE: `s_ready`=0, `par_write_en`=1 for exactly one cycle, with `par_out` holding the completed row.
  - `sub_tile_idx = row_cnt[4:3]`, `unit_tile_idx = row_cnt[2:0]`.
  - `row_cnt` increments.
  - If `row_cnt+1 == rows_latched` → DONE, else → FILL.
- DONE: `done`=1 for one cycle, `busy` drops in the same cycle, then → IDLE.
- `par_out` holds its value outside WRITE. Lanes not yet overwritten in the current row keep their previous-row values; there is no zero fill.
- `s_valid` without `s_ready` has no effect; no data is dropped or duplicated.
- `start` in any state other than IDLE is ignored. `num_rows` changes after the start cycle are ignored.
- Reset mid-load aborts the load immediately with no write and no `done`. On reset:
  - `par_out`, all counters and `checksum` = 0.
  - FSM = IDLE.
  - `s_ready`, `par_write_en`, `busy`, `done` = 0.
  - `sub_tile_idx` = 0, `unit_tile_idx` = 0.

## Timing
- Beat accepted at edge t completes a row → `par_write_en` is high during cycle t+1 → `s_ready` high again at t+2 if more rows remain.
- Per row: 64/IN_WORDS fill cycles + 1 write cycle. With IN_WORDS=4, a 32-row tile takes 32×17 = 544 cycles minimum from the first `s_ready`.
- Accepted `start` at edge t: `busy`=1 and `s_ready`=1 from cycle t+1.
- Final write in cycle w → `done` in cycle w+1.
- Zero-row load: `start` at t → `done` in cycle t+1, no write.
- Output indices and `par_out` are registered; no combinational path from `s_data` to the buffer.

## Configuration
- `PARAM_LOADER_CHECKSUM_EN` defined:
  - `checksum` port present.
  - Holds a 32-bit wrapping sum of every accepted word of the current load; cleared on accepted `start`.
  - Valid and stable from `done` until the next accepted `start`.
- Not defined: port and accumulator absent; all other behaviour identical.

## Structure
- Shared package `accel_pkg`:
  - `PE_LANES = 64`, `WORD_W = 32`, `ROWS_PER_TILE = 32`.
  - `param_word_t` typedef.
  - FSM state enum `param_ld_state_t`.
- One sub-module, `param_row_packer`: the lane register array plus beat counter, with inputs beat and write-strobe, outputs row and row-complete. The FSM, row counter and checksum stay in `param_loader`.

## Test plan
- IN_WORDS=4, `num_rows`=1, 16 beats with word value = lane index (0..63), `s_valid` held high → single `par_write_en` at cycle 17 after the first beat. `par_out[i] == i`, both indices 0, `done` one cycle later.
- `num_rows`=32, data = row*64+lane → 32 writes with (sub, unit) stepping (0,0)…(0,7),(1,0)…(3,7); each row's data correct; `done` once.
- Random `s_valid` gaps (50%) on a 3-row load → identical rows and indices to the gap-free run; no extra writes.
- `num_rows`=0 → `done` the cycle after `start`, no write. `num_rows`=40 → exactly 32 writes.
- Assert `rst` after row 2 of 5, mid-fill → all outputs 0 next cycle, no `done`. A fresh `start` then loads normally from row index 0.
- `PARAM_LOADER_CHECKSUM_EN`, 1 row of all 0xFFFFFFFF → `checksum` = 0xFFFFFFC0 at `done`. A second `start` pulsed during busy is ignored.
